// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staggered reset-release sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } seq_state_t;

    // Width of a counter that must reach max(hold, stagger) - 1 and be compared against it.
    function automatic int cnt_width(input int hold, input int stagger);
        int m;
        m = (hold > stagger) ? hold : stagger;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert bit: the chain is set immediately by i_rst_n low and drains zeros on each edge.
module reset_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign o_rst_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Asserts all domain resets asynchronously, then releases them one by one (channel 0 first)
// after a hold period, with a software re-reset path and a completion flag.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                    sync_clk,
    input  logic                    reset_async_n,
    input  logic                    sw_reset_req,
    output logic [NUM_CHANNELS-1:0] reset_out,
    output logic                    seq_busy,
    output logic                    seq_done,
    output logic [1:0]              o_dbg_state
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CHANNELS - 1);

    seq_state_t              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_CHANNELS-1:0] r_reset_out;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_rst_sync;
    logic [NUM_CHANNELS-1:0] w_idx_mask;

    reset_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk      (sync_clk),
        .i_rst_n    (reset_async_n),
        .o_rst_sync (w_rst_sync)
    );

    always_comb begin
        w_idx_mask = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_idx_mask[i] = (r_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge sync_clk or negedge reset_async_n) begin
        if (!reset_async_n) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_reset_out <= '1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else if (sw_reset_req && (r_state != HOLD)) begin
            // Re-assert every channel at once so no domain is left half released.
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_reset_out <= '1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_rst_sync || sw_reset_req) begin
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_reset_out[0] <= 1'b0;
                        r_cnt          <= '0;
                        if (NUM_CHANNELS == 1) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RELEASE;
                            r_idx   <= IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt == STAGGER_LAST) begin
                        r_reset_out <= r_reset_out & ~w_idx_mask;
                        r_cnt       <= '0;
                        r_idx       <= r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
        end
    end

    assign reset_out   = r_reset_out;
    assign seq_busy    = r_busy;
    assign seq_done    = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboarded bench: a release-count model predicts outputs per edge for a default and a corner instance.
module tb_reset_release_sequencer;

    localparam int N0 = 4;
    localparam int W  = N0 + 2;

    logic sync_clk      = 1'b0;
    logic reset_async_n = 1'b0;
    logic sw_reset_req  = 1'b0;

    logic [N0-1:0] ro0;
    logic          busy0, done0;
    logic [1:0]    st0;
    logic [0:0]    ro1;
    logic          busy1, done1;
    logic [1:0]    st1;

    always #5 sync_clk = ~sync_clk;

    reset_release_sequencer #(
        .NUM_CHANNELS(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(8)
    ) dut0 (
        .sync_clk(sync_clk), .reset_async_n(reset_async_n), .sw_reset_req(sw_reset_req),
        .reset_out(ro0), .seq_busy(busy0), .seq_done(done0), .o_dbg_state(st0)
    );

    reset_release_sequencer #(
        .NUM_CHANNELS(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
    ) dut1 (
        .sync_clk(sync_clk), .reset_async_n(reset_async_n), .sw_reset_req(sw_reset_req),
        .reset_out(ro1), .seq_busy(busy1), .seq_done(done1), .o_dbg_state(st1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // Reference model: per instance, edges seen since reset release, length of the current
    // qualifying run, and how many channels have been released so far.
    int p_n[2]     = '{4, 1};
    int p_sync[2]  = '{2, 3};
    int p_hold[2]  = '{16, 1};
    int p_stag[2]  = '{8, 1};
    int m_edges[2] = '{0, 0};
    int m_run[2]   = '{0, 0};
    int m_rel[2]   = '{0, 0};

    function automatic logic [W-1:0] model_vec(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < p_n[k]; i++) v[i] = (i >= m_rel[k]);
        v[N0]   = (m_rel[k] < p_n[k]);
        v[N0+1] = (m_rel[k] == p_n[k]);
        return v;
    endfunction

    task automatic model_reset(input int k);
        m_edges[k] = 0;
        m_run[k]   = 0;
        m_rel[k]   = 0;
    endtask

    task automatic model_step(input int k, input logic arst_n, input logic sw);
        logic held;
        if (!arst_n) begin
            model_reset(k);
            return;
        end
        if (m_edges[k] <= p_sync[k]) m_edges[k]++;
        held = (m_edges[k] <= p_sync[k]);
        if (m_rel[k] == 0) begin
            if (held || sw) begin
                m_run[k] = 0;
            end else begin
                m_run[k]++;
                if (m_run[k] == p_hold[k]) begin
                    m_rel[k] = 1;
                    m_run[k] = 0;
                end
            end
        end else if (sw) begin
            m_rel[k] = 0;
            m_run[k] = 0;
        end else if (m_rel[k] < p_n[k]) begin
            m_run[k]++;
            if (m_run[k] == p_stag[k]) begin
                m_rel[k]++;
                m_run[k] = 0;
            end
        end
    endtask

    always @(posedge sync_clk) begin
        for (int k = 0; k < 2; k++) model_step(k, reset_async_n, sw_reset_req);
        exp_q0.push_back(model_vec(0));
        exp_q1.push_back(model_vec(1));
    end

    // An asynchronous assertion between edges changes what the next sample must show.
    always @(negedge reset_async_n) begin
        if (exp_q0.size() != 0) begin
            model_reset(0);
            model_reset(1);
            exp_q0.delete();
            exp_q1.delete();
            exp_q0.push_back(model_vec(0));
            exp_q1.push_back(model_vec(1));
        end
    end

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic mon_on = 1'b1;

    always @(negedge sync_clk) begin
        logic [3:0] z;
        if (mon_on) begin
            if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                cmp("sb_main", {done0, busy0, ro0}, exp_q0.pop_front());
                cmp("sb_corner", {done1, busy1, 3'b000, ro1}, exp_q1.pop_front());
            end
            z = ~ro0;
            n_cmp++;
            if ((z & (z + 4'd1)) != 4'd0) begin
                n_bad++;
                $display("FAIL thermometer: got %b expected thermometer shape at %0t", ro0, $time);
            end
        end
    end

    // Called at posedge+1 just after the last edge that starts the sequence; counts edges from there.
    task automatic run_to_done(input string name, input int exp_b0, input int exp_d0, input int exp_d1);
        int e, b0, d0, d1;
        e = 0; b0 = 0; d0 = 0; d1 = 0;
        while (e < 100 && d0 == 0) begin
            @(posedge sync_clk);
            #1;
            e++;
            if (b0 == 0 && ro0[0] == 1'b0) b0 = e;
            if (d1 == 0 && done1) d1 = e;
            if (done0) d0 = e;
        end
        cmp_int({name, "_bit0_edge"}, b0, exp_b0);
        cmp_int({name, "_done_edge"}, d0, exp_d0);
        cmp_int({name, "_corner_done_edge"}, d1, exp_d1);
    endtask

    initial begin
        int r, e;
        reset_async_n = 1'b0;
        sw_reset_req  = 1'b0;
        repeat (5) @(posedge sync_clk);
        #1;
        cmp("reset_state", {done0, busy0, ro0}, 6'b01_1111);
        reset_async_n = 1'b1;
        run_to_done("powerup", 18, 42, 4);

        repeat (3) @(posedge sync_clk);
        #1;
        sw_reset_req = 1'b1;
        repeat (3) @(posedge sync_clk);
        #1;
        sw_reset_req = 1'b0;
        run_to_done("sw_from_done", 16, 40, 1);

        sw_reset_req = 1'b1;
        @(posedge sync_clk);
        #1;
        sw_reset_req = 1'b0;
        e = 0;
        while (e < 100 && ro0[1] != 1'b0) begin
            @(posedge sync_clk);
            #1;
            e++;
        end
        cmp_int("bit1_clear_edge", e, 24);
        sw_reset_req = 1'b1;
        @(posedge sync_clk);
        #1;
        sw_reset_req = 1'b0;
        cmp("mid_release_rereset", {done0, busy0, ro0}, 6'b01_1111);
        run_to_done("sw_mid_release", 16, 40, 1);

        reset_async_n = 1'b0;
        repeat (2) @(posedge sync_clk);
        #1;
        reset_async_n = 1'b1;
        repeat (30) @(posedge sync_clk);
        #3;
        reset_async_n = 1'b0;
        #1;
        cmp("arst_immediate", {done0, busy0, ro0}, 6'b01_1111);
        cmp("arst_immediate_corner", {done1, busy1, 3'b000, ro1}, 6'b01_0001);
        repeat (2) @(posedge sync_clk);
        #1;
        reset_async_n = 1'b1;
        run_to_done("arst_restart", 18, 42, 4);

        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 299);
            if (r < 2) begin
                #2;
                reset_async_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge sync_clk);
                #1;
                reset_async_n = 1'b1;
            end else if (r < 8) begin
                sw_reset_req = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge sync_clk);
                #1;
                sw_reset_req = 1'b0;
            end else begin
                @(posedge sync_clk);
                #1;
            end
        end

        repeat (60) @(posedge sync_clk);
        #1;
        cmp("soak_settles_done", {done0, busy0, ro0}, 6'b10_0000);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
